// File: rtl/fetch_byte_queue.sv
// Instruction-byte staging queue: fetch beats in, left-aligned decode window out.
// Optional over-consume checking is enabled by defining FETCH_QUEUE_OVERCONSUME_CHECK_EN.
module fetch_byte_queue #(
   parameter int FETCH_BYTES  = 8,
   parameter int DEPTH_BYTES  = 32,
   parameter int WINDOW_BYTES = 15
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [FETCH_BYTES*8-1:0]          in_data,
   input  logic                              flush,
   input  logic [63:0]                       flush_pc,
   output logic [WINDOW_BYTES*8-1:0]         win_bytes,
   output logic [$clog2(WINDOW_BYTES+1)-1:0] win_count,
   output logic [63:0]                       win_pc,
   input  logic                              consume_valid,
   input  logic [$clog2(WINDOW_BYTES+1)-1:0] consume_count
`ifdef FETCH_QUEUE_OVERCONSUME_CHECK_EN
   ,
   output logic                              overconsume_err
`endif
);

   localparam int CW = $clog2(WINDOW_BYTES + 1);
   localparam int OW = $clog2(DEPTH_BYTES + 1);
   localparam int IW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
   localparam int KW = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;

   logic [7:0]    mem_r      [DEPTH_BYTES];
   logic [7:0]    mem_next_s [DEPTH_BYTES];
   logic [7:0]    beat_s     [FETCH_BYTES];
   logic [OW-1:0] occ_r;
   logic [OW-1:0] occ_next_s;
   logic [OW-1:0] tail_s;
   logic [63:0]   pc_r;
   logic [63:0]   pc_next_s;
   logic [CW-1:0] eff_s;
   logic          push_s;

   // Occupancy-derived handshake and window outputs (registered state only)
   always_comb begin
      in_ready  = ((OW'(DEPTH_BYTES) - occ_r) >= OW'(FETCH_BYTES));
      win_pc    = pc_r;
      win_count = {CW{1'b0}};
      if (occ_r >= OW'(WINDOW_BYTES)) begin
         win_count = CW'(WINDOW_BYTES);
      end else begin
         win_count = CW'(occ_r);
      end
      win_bytes = {(WINDOW_BYTES*8){1'b0}};
      for (int i = 0; i < WINDOW_BYTES; i++) begin
         if (i < int'(win_count)) begin
            win_bytes[(WINDOW_BYTES-1-i)*8 +: 8] = mem_r[IW'(i)];
         end else begin
            win_bytes[(WINDOW_BYTES-1-i)*8 +: 8] = 8'h00;
         end
      end
   end

   // Effective consume amount: legal counts pass, illegal ones are dropped or saturated
   always_comb begin
      eff_s = {CW{1'b0}};
      if (consume_valid) begin
         if (consume_count <= win_count) begin
            eff_s = consume_count;
         end else begin
`ifdef FETCH_QUEUE_OVERCONSUME_CHECK_EN
            eff_s = {CW{1'b0}};
`else
            eff_s = win_count;
`endif
         end
      end else begin
         eff_s = {CW{1'b0}};
      end
   end

   // Unpack the beat so byte 0 (lowest address, MSB) lands at index 0
   always_comb begin
      for (int k = 0; k < FETCH_BYTES; k++) begin
         beat_s[KW'(k)] = in_data[(FETCH_BYTES-1-k)*8 +: 8];
      end
   end

   assign push_s = in_valid && in_ready && !flush;
   assign tail_s = occ_r - OW'(eff_s);

   // Next storage image: shift out consumed bytes, then append the beat at the new tail
   always_comb begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
         mem_next_s[IW'(i)] = 8'h00;
         if (flush) begin
            mem_next_s[IW'(i)] = 8'h00;
         end else if (push_s && (i >= int'(tail_s)) && (i < int'(tail_s) + FETCH_BYTES)) begin
            mem_next_s[IW'(i)] = beat_s[KW'(i - int'(tail_s))];
         end else if ((i + int'(eff_s)) < int'(occ_r)) begin
            mem_next_s[IW'(i)] = mem_r[IW'(i + int'(eff_s))];
         end else begin
            mem_next_s[IW'(i)] = 8'h00;
         end
      end
   end

   // Next occupancy and PC; flush overrides push and consume
   always_comb begin
      occ_next_s = occ_r;
      pc_next_s  = pc_r;
      if (flush) begin
         occ_next_s = {OW{1'b0}};
         pc_next_s  = flush_pc;
      end else if (push_s) begin
         occ_next_s = occ_r - OW'(eff_s) + OW'(FETCH_BYTES);
         pc_next_s  = pc_r + 64'(eff_s);
      end else begin
         occ_next_s = occ_r - OW'(eff_s);
         pc_next_s  = pc_r + 64'(eff_s);
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ_r <= {OW{1'b0}};
         pc_r  <= 64'h0;
         for (int i = 0; i < DEPTH_BYTES; i++) begin
            mem_r[IW'(i)] <= 8'h00;
         end
      end else begin
         occ_r <= occ_next_s;
         pc_r  <= pc_next_s;
         for (int i = 0; i < DEPTH_BYTES; i++) begin
            mem_r[IW'(i)] <= mem_next_s[IW'(i)];
         end
      end
   end

`ifdef FETCH_QUEUE_OVERCONSUME_CHECK_EN
   logic illegal_s;
   logic err_r;

   // A flush cycle ignores the consume, so it cannot raise the error either
   assign illegal_s = consume_valid && (consume_count > win_count) && !flush;

   // Sticky over-consume flag, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (illegal_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign overconsume_err = err_r;
`endif

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Self-checking bench for fetch_byte_queue: directed scenarios plus a
// byte-queue reference model feeding a scoreboard of expected windows.
module tb_fetch_byte_queue;

   localparam int FB = 8;
   localparam int DB = 32;
   localparam int WB = 15;
   localparam int CW = 4;
`ifdef FETCH_QUEUE_OVERCONSUME_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [FB*8-1:0] in_data = '0;
   logic            flush = 1'b0;
   logic [63:0]     flush_pc = '0;
   logic [WB*8-1:0] win_bytes;
   logic [CW-1:0]   win_count;
   logic [63:0]     win_pc;
   logic            consume_valid = 1'b0;
   logic [CW-1:0]   consume_count = '0;
   logic            err_obs;

   fetch_byte_queue #(.FETCH_BYTES(FB), .DEPTH_BYTES(DB), .WINDOW_BYTES(WB)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .flush(flush), .flush_pc(flush_pc),
      .win_bytes(win_bytes), .win_count(win_count), .win_pc(win_pc),
      .consume_valid(consume_valid), .consume_count(consume_count)
`ifdef FETCH_QUEUE_OVERCONSUME_CHECK_EN
      , .overconsume_err(err_obs)
`endif
   );
`ifndef FETCH_QUEUE_OVERCONSUME_CHECK_EN
   assign err_obs = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0]   cnt;
      logic [63:0]     pc;
      logic [WB*8-1:0] bytes;
      logic            rdy;
      logic            err;
   } exp_t;

   exp_t        sb_q[$];
   logic [7:0]  m_q[$];
   logic [63:0] m_pc;
   bit          m_err;
   int          n_tests = 0;
   int          n_fail = 0;

   function automatic exp_t snap();
      exp_t e;
      int n = m_q.size();
      e.cnt   = CW'((n > WB) ? WB : n);
      e.pc    = m_pc;
      e.bytes = '0;
      for (int i = 0; i < WB; i++) if (i < n) e.bytes[(WB-1-i)*8 +: 8] = m_q[i];
      e.rdy   = ((DB - n) >= FB);
      e.err   = m_err;
      return e;
   endfunction

   function automatic logic [63:0] seq_beat(input int b);
      logic [63:0] d;
      for (int k = 0; k < FB; k++) d[(FB-1-k)*8 +: 8] = 8'(b*FB + k);
      return d;
   endfunction

   // Drive one cycle, advance the reference model, optionally queue the expected window
   task automatic step(input bit iv, input logic [63:0] d, input bit cv, input int cc,
                       input bit fl, input logic [63:0] fpc, input bit chk);
      bit rdy, acc;
      int wc, eff;
      in_valid = iv; in_data = d; consume_valid = cv; consume_count = CW'(cc);
      flush = fl; flush_pc = fpc;
      rdy = ((DB - m_q.size()) >= FB);
      acc = iv && rdy && !fl;
      wc  = (m_q.size() > WB) ? WB : m_q.size();
      if (fl) begin
         m_q.delete();
         m_pc = fpc;
      end else begin
         eff = 0;
         if (cv) begin
            if (cc <= wc) eff = cc;
            else begin
               if (CHECK) m_err = 1'b1;
               eff = CHECK ? 0 : wc;
            end
         end
         for (int i = 0; i < eff; i++) void'(m_q.pop_front());
         m_pc = m_pc + 64'(eff);
         if (acc) for (int k = 0; k < FB; k++) m_q.push_back(d[(FB-1-k)*8 +: 8]);
      end
      if (chk) sb_q.push_back(snap());
      @(posedge clk); #1;
      in_valid = 1'b0; consume_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0102_0304;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (win_count !== 4'd0 || win_bytes !== '0 || win_pc !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_window: cnt=%0d pc=%h bytes=%h, expected all zero", win_count, win_pc, win_bytes);
      end
      n_tests++;
      if (in_ready !== 1'b1 || err_obs !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: in_ready=%b err=%b, expected 1/0", in_ready, err_obs);
      end
      in_valid = 1'b0; reset = 1'b0;
      m_q.delete(); m_pc = '0; m_err = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_beat();
      step(1, 64'h4889_E5C3_9090_9090, 0, 0, 0, 0, 0);
      n_tests++;
      if (win_count !== 4'd8 || win_pc !== 64'h0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_beat_ctl: cnt=%0d pc=%h rdy=%b, expected 8/0/1", win_count, win_pc, in_ready);
      end
      n_tests++;
      if (win_bytes !== {64'h4889_E5C3_9090_9090, 56'h0}) begin
         n_fail++;
         $display("FAIL single_beat_bytes: got %h expected %h", win_bytes, {64'h4889_E5C3_9090_9090, 56'h0});
      end
   endtask

   task automatic test_back_to_back();
      logic [WB*8-1:0] expb;
      exp_t e;
      step(0, 0, 0, 0, 1, 64'h40_0000, 0);
      for (int b = 0; b < 5; b++) begin
         n_tests++;
         if (in_ready !== (b < 4)) begin
            n_fail++;
            $display("FAIL b2b_ready[%0d]: in_ready=%b expected %b", b, in_ready, (b < 4));
         end
         step(1, seq_beat(b), 0, 0, 0, 0, 0);
      end
      step(1, seq_beat(4), 1, 3, 0, 0, 0);
      n_tests++;
      if (win_pc !== 64'h40_0003 || win_count !== 4'd15 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_consume3: pc=%h cnt=%0d rdy=%b, expected 400003/15/0", win_pc, win_count, in_ready);
      end
      step(1, seq_beat(4), 1, 8, 0, 0, 0);
      n_tests++;
      if (in_ready !== 1'b1 || win_pc !== 64'h40_000B) begin
         n_fail++;
         $display("FAIL b2b_reopen: rdy=%b pc=%h, expected 1/40000b", in_ready, win_pc);
      end
      step(1, seq_beat(4), 0, 0, 0, 0, 0);
      step(0, 0, 1, 15, 0, 0, 1);
      expb = '0;
      for (int i = 0; i < 14; i++) expb[(WB-1-i)*8 +: 8] = 8'(26 + i);
      n_tests++;
      if (win_count !== 4'd14 || win_pc !== 64'h40_001A || win_bytes !== expb) begin
         n_fail++;
         $display("FAIL b2b_tail: cnt=%0d pc=%h bytes=%h, expected 14/40001a/%h", win_count, win_pc, win_bytes, expb);
      end
      e = sb_q.pop_front();
      n_tests++;
      if (win_bytes !== e.bytes || in_ready !== e.rdy) begin
         n_fail++;
         $display("FAIL b2b_model: bytes=%h rdy=%b, expected %h/%b", win_bytes, in_ready, e.bytes, e.rdy);
      end
   endtask

   task automatic test_push_consume();
      step(0, 0, 0, 0, 1, 64'h0, 0);
      step(1, 64'hA0A1_A2A3_A4A5_A6A7, 0, 0, 0, 0, 0);
      step(1, 64'hB0B1_B2B3_B4B5_B6B7, 1, 5, 0, 0, 0);
      n_tests++;
      if (win_count !== 4'd11 || win_pc !== 64'h5 ||
          win_bytes !== {24'hA5A6A7, 64'hB0B1_B2B3_B4B5_B6B7, 32'h0}) begin
         n_fail++;
         $display("FAIL push_consume: cnt=%0d pc=%h bytes=%h, expected 11/5/a5a6a7b0..b7+zeros", win_count, win_pc, win_bytes);
      end
   endtask

   task automatic test_flush_priority();
      step(1, 64'hC0C1_C2C3_C4C5_C6C7, 1, 2, 1, 64'h1000, 0);
      n_tests++;
      if (win_count !== 4'd0 || win_pc !== 64'h1000 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_prio: cnt=%0d pc=%h rdy=%b, expected 0/1000/1", win_count, win_pc, in_ready);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (win_count !== 4'd0 || win_bytes !== '0) begin
         n_fail++;
         $display("FAIL flush_drop: cnt=%0d bytes=%h, expected 0/0", win_count, win_bytes);
      end
      step(1, 64'hC0C1_C2C3_C4C5_C6C7, 0, 0, 0, 0, 0);
      n_tests++;
      if (win_count !== 4'd8 || win_bytes !== {64'hC0C1_C2C3_C4C5_C6C7, 56'h0} || win_pc !== 64'h1000) begin
         n_fail++;
         $display("FAIL flush_refill: cnt=%0d pc=%h bytes=%h, expected 8/1000/c0..c7", win_count, win_pc, win_bytes);
      end
   endtask

   task automatic test_overconsume();
      step(0, 0, 0, 0, 1, 64'h2000, 0);
      step(1, 64'hD0D1_D2D3_D4D5_D6D7, 0, 0, 0, 0, 0);
      step(0, 0, 1, 5, 0, 0, 0);
      n_tests++;
      if (win_count !== 4'd3 || win_pc !== 64'h2005) begin
         n_fail++;
         $display("FAIL over_setup: cnt=%0d pc=%h, expected 3/2005", win_count, win_pc);
      end
      step(0, 0, 1, 4, 0, 0, 0);
      n_tests++;
      if (CHECK) begin
         if (win_count !== 4'd3 || win_pc !== 64'h2005 || err_obs !== 1'b1 ||
             win_bytes !== {24'hD5D6D7, 96'h0}) begin
            n_fail++;
            $display("FAIL over_checked: cnt=%0d pc=%h err=%b, expected 3/2005/1", win_count, win_pc, err_obs);
         end
      end else begin
         if (win_count !== 4'd0 || win_pc !== 64'h2008 || win_bytes !== '0) begin
            n_fail++;
            $display("FAIL over_saturate: cnt=%0d pc=%h, expected 0/2008", win_count, win_pc);
         end
      end
      step(0, 0, 0, 0, 1, 64'h3000, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      n_tests++;
      if (win_count !== 4'd0 || win_pc !== 64'h3000 || err_obs !== CHECK) begin
         n_fail++;
         $display("FAIL over_empty: cnt=%0d pc=%h err=%b, expected 0/3000/%b", win_count, win_pc, err_obs, CHECK);
      end
   endtask

   task automatic test_async_reset();
      step(1, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      n_tests++;
      if (win_count !== 4'd0 || win_pc !== 64'h0 || win_bytes !== '0 || in_ready !== 1'b1 || err_obs !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: cnt=%0d pc=%h rdy=%b err=%b, expected 0/0/1/0", win_count, win_pc, in_ready, err_obs);
      end
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; reset = 1'b0;
      m_q.delete(); m_pc = '0; m_err = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (win_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_blocks_push: cnt=%0d expected 0", win_count);
      end
   endtask

   task automatic test_random();
      exp_t e;
      bit fl, cv;
      step(0, 0, 0, 0, 1, {$urandom, $urandom}, 0);
      for (int c = 0; c < 300; c++) begin
         fl = ($urandom_range(0, 31) == 0);
         cv = !fl && ($urandom_range(0, 1) == 1);
         step($urandom_range(0, 2) != 0, {$urandom, $urandom}, cv, $urandom_range(0, 15),
              fl, {$urandom, $urandom}, 1);
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL random[%0d]: scoreboard empty, expected one entry", c);
         end else begin
            e = sb_q.pop_front();
            if (win_count !== e.cnt || win_pc !== e.pc || win_bytes !== e.bytes ||
                in_ready !== e.rdy || err_obs !== e.err) begin
               n_fail++;
               $display("FAIL random[%0d]: cnt=%0d pc=%h rdy=%b err=%b bytes=%h, expected cnt=%0d pc=%h rdy=%b err=%b bytes=%h",
                        c, win_count, win_pc, in_ready, err_obs, win_bytes, e.cnt, e.pc, e.rdy, e.err, e.bytes);
            end
         end
      end
   endtask

   initial begin
      m_pc = '0; m_err = 1'b0;
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_push_consume();
      test_flush_priority();
      test_overconsume();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
